// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART handshake: queues bytes and hands them
// over one at a time as TX_DI/TX_DRDY, waiting for TX_DONE between bytes.
//
// state     | meaning
// IDLE      | no byte in flight; pops the head entry as soon as one is queued
// SEND      | TX_DRDY pulse cycle
// WAIT_DONE | byte in flight, TX_DI held until the UART reports TX_DONE
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [DATA_BITS-1:0] i_wr_di,
    input  logic                 i_flush,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [DEPTH_LOG2:0]  o_count,
    output logic                 o_overflow,
    output logic [DATA_BITS-1:0] o_tx_di,
    output logic                 o_tx_drdy,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_BITS-1:0]  r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_tx_drdy;
    logic [DATA_BITS-1:0]  r_tx_di;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_load;
    logic                  w_unused;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en & ~i_flush & ~w_full;
    // Busy is status only; the sender paces itself purely on TX_DONE.
    assign w_unused = i_tx_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_load)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A pop in the same cycle does not rescue a write issued while full.
            r_overflow <= i_wr_en & w_full;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wr_di;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_load) w_state_next = SEND;
            SEND:      w_state_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        if (r_state == IDLE && !w_empty && !i_flush)
            w_load = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_drdy <= 1'b0;
            r_tx_di   <= '0;
        end else begin
            r_tx_drdy <= w_load;
            if (w_load)
                r_tx_di <= r_mem[r_rd_ptr];
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_di    = r_tx_di;
    assign o_tx_drdy  = r_tx_drdy;
endmodule
